// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the PC, issues in-order imem requests, pairs responses with PCs, buffers for decode.
// Response at edge N is visible on id_* after edge N; requests stall once in-flight + dropped + buffered reach DEPTH.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {RUN, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   q_rd_q, q_rd_d, q_wr_q, q_wr_d;
   logic [PW-1:0]   pp_rd_q, pp_rd_d, pp_wr_q, pp_wr_d;
   logic            id_valid_q, id_valid_d;
   logic [31:0]     id_instr_q, id_instr_d;
   logic [31:0]     id_pc_q, id_pc_d;

   logic [31:0]     q_instr_q [DEPTH];
   logic [31:0]     q_pc_q    [DEPTH];
   logic [31:0]     pp_q      [DEPTH];

   logic [CW:0]     occ;
   logic            req_fire, rsp_drop, rsp_take, q_push, q_pop;
   logic [31:0]     rsp_pc;

   // Dropped responses still occupy a slot until they return, so they count against DEPTH.
   assign occ            = {1'b0, inflight_q} + {1'b0, drop_q} + {1'b0, count_q};
   assign imem_req_valid = reset_n & (occ < DEPTH_C) & ~redirect_valid;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign rsp_drop       = imem_rsp_valid & (state_q == DRAIN);
   assign rsp_take       = imem_rsp_valid & (state_q == RUN) & (inflight_q != '0);
   assign rsp_pc         = pp_q[pp_rd_q];
   assign q_push         = rsp_take & ~redirect_valid;
   assign q_pop          = id_valid_q & id_ready & ~redirect_valid;

   assign id_valid = id_valid_q;
   assign id_instr = id_instr_q;
   assign id_pc    = id_pc_q;

   always_comb begin
      pc_d       = pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q - CW'(rsp_drop);
      count_d    = count_q;
      q_rd_d     = q_rd_q;
      q_wr_d     = q_wr_q;
      pp_wr_d    = pp_wr_q + PW'(req_fire);
      pp_rd_d    = pp_rd_q + PW'(rsp_drop | rsp_take);
      id_valid_d = 1'b0;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;

      if (redirect_valid) begin
         pc_d       = redirect_pc & 32'hFFFF_FFFC;
         inflight_d = '0;
         drop_d     = drop_q - CW'(rsp_drop) + inflight_q - CW'(rsp_take);
         count_d    = '0;
         q_rd_d     = '0;
         q_wr_d     = '0;
      end else begin
         if (req_fire) pc_d = pc_q + 32'd4;
         inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_take);
         count_d    = count_q + CW'(q_push) - CW'(q_pop);
         q_rd_d     = q_rd_q + PW'(q_pop);
         q_wr_d     = q_wr_q + PW'(q_push);
      end

      // Next head is either an existing slot or the word being written this edge.
      if (count_d != '0) begin
         id_valid_d = 1'b1;
         if (q_push && (q_rd_d == q_wr_q)) begin
            id_instr_d = imem_rsp_data;
            id_pc_d    = rsp_pc;
         end else begin
            id_instr_d = q_instr_q[q_rd_d];
            id_pc_d    = q_pc_q[q_rd_d];
         end
      end

      state_d = (drop_d != '0) ? DRAIN : RUN;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         count_q    <= '0;
         q_rd_q     <= '0;
         q_wr_q     <= '0;
         pp_rd_q    <= '0;
         pp_wr_q    <= '0;
         id_valid_q <= 1'b0;
         id_instr_q <= NOP;
         id_pc_q    <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         q_rd_q     <= q_rd_d;
         q_wr_q     <= q_wr_d;
         pp_rd_q    <= pp_rd_d;
         pp_wr_q    <= pp_wr_d;
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
      end
   end

   always_ff @(posedge clock) begin
      if (q_push) begin
         q_instr_q[q_wr_q] <= imem_rsp_data;
         q_pc_q[q_wr_q]    <= rsp_pc;
      end
      if (req_fire) pp_q[pp_wr_q] <= pc_q;
   end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: memory model returns hashed words per PC; expected delivery is the program-order PC stream.
module tb_if_fetch_queue;
   localparam int unsigned DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, id_instr, id_pc;
   logic        redirect_valid, id_ready, id_valid;

   logic        w_req_valid, w_req_ready, w_rsp_valid, w_redirect, w_id_ready, w_id_valid;
   logic [31:0] w_addr, w_rsp_data, w_redirect_pc, w_id_instr, w_id_pc;

   if_fetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc));

   if_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
      .clock(clock), .reset_n(reset_n),
      .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_addr),
      .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
      .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
      .id_ready(w_id_ready), .id_valid(w_id_valid), .id_instr(w_id_instr), .id_pc(w_id_pc));

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        rq[$];
   logic [31:0] w_acc[$];
   int          checks = 0, failures = 0;
   int          cyc = 0, n_acc = 0, n_del = 0;
   int          rr_pct = 100, idr_pct = 100, lat_lo = 1, lat_hi = 1;
   bit          rst_want = 1'b1;
   logic [31:0] exp_fetch = RST_PC, exp_id = RST_PC;
   logic        obs_id_valid, obs_req_valid;
   logic [31:0] obs_id_pc, obs_id_instr, obs_addr, del_pc;
   bit          acc_now, del_now;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // One clock cycle: drive at negedge, observe and score at negedge+1, update model after posedge.
   task automatic cycle(input bit redir, input logic [31:0] rpc);
      bit rsp_now;
      @(negedge clock);
      reset_n        = ~rst_want;
      rsp_now        = (rq.size() != 0) && (rq[0].due <= cyc) && !rst_want;
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? mem_word(rq[0].addr) : 32'hDEAD_BEEF;
      imem_req_ready = ($urandom_range(1, 100) <= rr_pct);
      id_ready       = ($urandom_range(1, 100) <= idr_pct);
      redirect_valid = redir && !rst_want;
      redirect_pc    = rpc;
      #1;
      obs_id_valid  = id_valid;
      obs_id_pc     = id_pc;
      obs_id_instr  = id_instr;
      obs_addr      = imem_req_addr;
      obs_req_valid = imem_req_valid;
      acc_now       = imem_req_valid && imem_req_ready;
      del_now       = id_valid && id_ready && !redirect_valid && !rst_want;
      if (rst_want || redirect_valid) begin
         checks++;
         if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL req_valid_blocked cyc=%0d got=%b exp=0", cyc, imem_req_valid);
         end
      end
      if (acc_now) begin
         checks++;
         if (imem_req_addr !== exp_fetch) begin
            failures++;
            $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_fetch);
         end
      end
      if (del_now) begin
         checks++;
         if (id_pc !== exp_id || id_instr !== mem_word(exp_id)) begin
            failures++;
            $display("FAIL id_word cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                     cyc, id_pc, id_instr, exp_id, mem_word(exp_id));
         end
         del_pc = id_pc;
         n_del++;
      end
      if (w_req_valid && w_req_ready) w_acc.push_back(w_addr);
      @(posedge clock);
      if (rst_want) begin
         rq.delete();
         exp_fetch = RST_PC;
         exp_id    = RST_PC;
      end else begin
         if (rsp_now) void'(rq.pop_front());
         if (acc_now) begin
            rq.push_back('{addr: obs_addr, due: cyc + $urandom_range(lat_lo, lat_hi)});
            exp_fetch = exp_fetch + 32'd4;
            n_acc++;
         end
         if (del_now) exp_id = exp_id + 32'd4;
         if (redirect_valid) begin
            exp_fetch = rpc & 32'hFFFF_FFFC;
            exp_id    = rpc & 32'hFFFF_FFFC;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      rst_want = 1'b1;
      repeat (2) cycle(1'b0, 32'h0);
      rst_want = 1'b0;
      n_acc = 0;
      n_del = 0;
   endtask

   task automatic test_reset();
      rr_pct = 100; idr_pct = 100; lat_lo = 1; lat_hi = 1;
      do_reset();
      cycle(1'b0, 32'h0);
      checks++;
      if (obs_id_valid !== 1'b0) begin failures++; $display("FAIL rst_id_valid got=%b exp=0", obs_id_valid); end
      checks++;
      if (obs_id_instr !== 32'h0000_0013) begin failures++; $display("FAIL rst_id_instr got=%h exp=00000013", obs_id_instr); end
      checks++;
      if (obs_id_pc !== RST_PC) begin failures++; $display("FAIL rst_id_pc got=%h exp=%h", obs_id_pc, RST_PC); end
      checks++;
      if (obs_addr !== RST_PC) begin failures++; $display("FAIL rst_req_addr got=%h exp=%h", obs_addr, RST_PC); end
      checks++;
      if (obs_req_valid !== 1'b1) begin failures++; $display("FAIL rst_req_valid got=%b exp=1", obs_req_valid); end
   endtask

   task automatic test_sequential();
      rr_pct = 100; idr_pct = 100; lat_lo = 1; lat_hi = 1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0);
         checks++;
         if (obs_id_valid !== (i == 2)) begin
            failures++;
            $display("FAIL seq_id_valid i=%0d got=%b exp=%b", i, obs_id_valid, (i == 2));
         end
      end
      checks++;
      if (obs_id_pc !== RST_PC) begin failures++; $display("FAIL seq_first_pc got=%h exp=%h", obs_id_pc, RST_PC); end
      repeat (20) cycle(1'b0, 32'h0);
      checks++;
      if (n_del < 6) begin failures++; $display("FAIL seq_throughput got=%0d exp>=6", n_del); end
   endtask

   task automatic test_backpressure();
      rr_pct = 100; idr_pct = 0; lat_lo = 1; lat_hi = 1;
      do_reset();
      repeat (11) begin
         cycle(1'b0, 32'h0);
         if (obs_id_valid) begin
            checks++;
            if (obs_id_pc !== RST_PC || obs_id_instr !== mem_word(RST_PC)) begin
               failures++;
               $display("FAIL bp_hold got pc=%h instr=%h exp pc=%h instr=%h",
                        obs_id_pc, obs_id_instr, RST_PC, mem_word(RST_PC));
            end
         end
      end
      checks++;
      if (n_acc > DEPTH) begin failures++; $display("FAIL bp_accepts got=%0d exp<=%0d", n_acc, DEPTH); end
      checks++;
      if (obs_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%b exp=0", obs_req_valid); end
      checks++;
      if (obs_id_valid !== 1'b1) begin failures++; $display("FAIL bp_id_valid got=%b exp=1", obs_id_valid); end
      idr_pct = 100;
      repeat (20) cycle(1'b0, 32'h0);
      checks++;
      if (n_del < 4) begin failures++; $display("FAIL bp_release got=%0d exp>=4", n_del); end
   endtask

   task automatic test_redirect_inflight();
      logic [31:0] got[$];
      rr_pct = 100; idr_pct = 100; lat_lo = 3; lat_hi = 3;
      do_reset();
      repeat (2) cycle(1'b0, 32'h0);
      cycle(1'b1, 32'h0000_0100);
      for (int i = 0; i < 40 && got.size() < 2; i++) begin
         cycle(1'b0, 32'h0);
         if (del_now) got.push_back(del_pc);
      end
      checks++;
      if (got.size() < 2) begin
         failures++;
         $display("FAIL redir_timeout got=%0d words exp=2", got.size());
      end else if (got[0] !== 32'h100 || got[1] !== 32'h104) begin
         failures++;
         $display("FAIL redir_pcs got=%h,%h exp=00000100,00000104", got[0], got[1]);
      end
      cycle(1'b1, 32'h0000_0103);
      acc_now = 1'b0;
      for (int i = 0; i < 20 && !acc_now; i++) cycle(1'b0, 32'h0);
      checks++;
      if (!acc_now || obs_addr !== 32'h100) begin
         failures++;
         $display("FAIL redir_align got acc=%b addr=%h exp addr=00000100", acc_now, obs_addr);
      end
   endtask

   task automatic test_redirect_with_rsp();
      bit seen;
      rr_pct = 100; idr_pct = 100; lat_lo = 1; lat_hi = 1;
      do_reset();
      repeat (2) cycle(1'b0, 32'h0);
      cycle(1'b1, 32'h0000_0200);
      checks++;
      if (obs_id_valid !== 1'b1) begin failures++; $display("FAIL rr_pre_valid got=%b exp=1", obs_id_valid); end
      cycle(1'b0, 32'h0);
      checks++;
      if (obs_id_valid !== 1'b0) begin failures++; $display("FAIL rr_flush got=%b exp=0", obs_id_valid); end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle(1'b0, 32'h0);
         seen = del_now;
      end
      checks++;
      if (!seen || del_pc !== 32'h200) begin
         failures++;
         $display("FAIL rr_next got seen=%b pc=%h exp pc=00000200", seen, del_pc);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] e;
      do_reset();
      w_acc.delete();
      repeat (8) cycle(1'b0, 32'h0);
      checks++;
      if (w_acc.size() != 4) begin
         failures++;
         $display("FAIL wrap_count got=%0d exp=4", w_acc.size());
      end
      e = 32'hFFFF_FFF8;
      for (int i = 0; i < 4 && i < w_acc.size(); i++) begin
         checks++;
         if (w_acc[i] !== e) begin failures++; $display("FAIL wrap_addr i=%0d got=%h exp=%h", i, w_acc[i], e); end
         e = e + 32'd4;
      end
   endtask

   task automatic test_random();
      rr_pct = 50; idr_pct = 60; lat_lo = 1; lat_hi = 4;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            rst_want = 1'b1;
            cycle(1'b0, 32'h0);
            rst_want = 1'b0;
            cycle(1'b0, 32'h0);
            checks++;
            if (obs_id_valid !== 1'b0) begin failures++; $display("FAIL rand_reset got=%b exp=0", obs_id_valid); end
         end else begin
            cycle($urandom_range(0, 99) < 3, {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))});
         end
      end
      checks++;
      if (n_del < 50) begin failures++; $display("FAIL rand_progress got=%0d exp>=50", n_del); end
   endtask

   initial begin
      reset_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
      w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = '0;
      w_redirect = 1'b0; w_redirect_pc = '0; w_id_ready = 1'b0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_with_rsp();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
